turn_maneuver_controller: RTL and testbench

Sequences the drive motors of the line-following bot through lane following, node confirmation, forward offset and pivot turns. Sits between the 3-LED line sensor array, the route/turn-direction planner and the motor driver enables. Issues one `node_ack` per confirmed node so the planner can advance its route index. Detects lost-line and stalled-pivot faults.

---
 rtl/turn_ctrl_pkg.sv | 24 ++
 rtl/node_debounce.sv | 36 +++
 rtl/turn_maneuver_controller.sv | 219 +++++++++++++++++++++
 tb/tb_turn_maneuver_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/turn_ctrl_pkg.sv
// Shared types and encodings for the turn maneuver controller.
package turn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFollow,
    StConfirm,
    StAdvance,
    StPivotOut,
    StPivotIn,
    StDone,
    StFault
  } state_e;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;
  localparam logic [1:0] DIR_UTURN    = 2'b11;

endpackage

// File: rtl/node_debounce.sv
// Run-length counter of consecutive all-on sensor samples; flags a confirmed node.
module node_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic track,
  input  logic run,
  input  logic all_on,
  output logic confirm
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // The first all-on sample (outside a run) loads 1; a run keeps counting.
  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
    cnt_d   = '0;
    if (track && all_on) begin
      cnt_d = run ? cnt_inc : CW'(1);
    end
    confirm = track && all_on && (cnt_d == CntMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_maneuver_controller.sv
// Line-follower motor sequencer: follow, node confirm, advance, pivot turns.
// Optional lost-line fault enabled by defining TURN_LOST_LINE_TIMEOUT_EN.
module turn_maneuver_controller
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned ADVANCE_CYCLES   = 50000,
  parameter int unsigned PIVOT_MAX_CYCLES = 2000000,
  parameter int unsigned LOST_MAX_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] line_sensor,
  input  logic [1:0] turn_direction,
  input  logic       route_done,
  output logic [1:0] motor_left,
  output logic [1:0] motor_right,
  output logic       node_ack,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int unsigned AW = $clog2(ADVANCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(PIVOT_MAX_CYCLES + 1);
  localparam logic [AW-1:0] AdvMax  = AW'(ADVANCE_CYCLES);
  localparam logic [AW-1:0] AdvLast = AW'(ADVANCE_CYCLES - 1);
  localparam logic [PW-1:0] PivMax  = PW'(PIVOT_MAX_CYCLES);
  localparam logic [PW-1:0] PivLast = PW'(PIVOT_MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      pass_q, pass_d;
  logic [AW-1:0]   adv_q, adv_d;
  logic [PW-1:0]   piv_q, piv_d;
  logic [1:0]      corr_l_q, corr_r_q, corr_l_d, corr_r_d;
  logic [1:0]      ml_d, mr_d;
  logic            ack_d, busy_d, done_d, fault_d;
  logic            all_on, centre, confirm, piv_timeout, lost_timeout, in_pivot;

  assign all_on      = (line_sensor == 3'b111);
  assign centre      = line_sensor[1];
  assign piv_timeout = (piv_q >= PivLast);
  assign in_pivot    = (state_q == StPivotOut) || (state_q == StPivotIn);

  node_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_node_debounce (
    .clk    (clk),
    .reset  (reset),
    .track  ((state_q == StFollow) || (state_q == StConfirm)),
    .run    (state_q == StConfirm),
    .all_on (all_on),
    .confirm(confirm)
  );

`ifdef TURN_LOST_LINE_TIMEOUT_EN
  localparam int unsigned LW = $clog2(LOST_MAX_CYCLES + 1);
  localparam logic [LW-1:0] LostMax  = LW'(LOST_MAX_CYCLES);
  localparam logic [LW-1:0] LostLast = LW'(LOST_MAX_CYCLES - 1);

  logic [LW-1:0] lost_q, lost_d;
  logic          line_gone;

  assign line_gone    = (state_q == StFollow) && (line_sensor == 3'b000);
  assign lost_timeout = line_gone && (lost_q >= LostLast);

  always_comb begin
    lost_d = '0;
    if (line_gone) begin
      lost_d = (lost_q == LostMax) ? lost_q : lost_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end
`else
  logic unused_lost_max;
  assign unused_lost_max = |LOST_MAX_CYCLES;
  assign lost_timeout    = 1'b0;
`endif

  // Next-state logic; enable low overrides every transition.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: state_d = StFollow;
      StFollow, StConfirm: begin
        if (lost_timeout) begin
          state_d = StFault;
        end else if (confirm) begin
          if (route_done) begin
            state_d = StDone;
          end else begin
            dir_d   = turn_direction;
            state_d = StAdvance;
          end
        end else if (state_q == StFollow && all_on) begin
          state_d = StConfirm;
        end else if (state_q == StConfirm && !all_on) begin
          state_d = StFollow;
        end
      end
      StAdvance: begin
        if (adv_q >= AdvLast) begin
          if (dir_q == DIR_STRAIGHT) begin
            state_d = StFollow;
          end else begin
            pass_d  = '0;
            state_d = StPivotOut;
          end
        end
      end
      StPivotOut: begin
        if (!centre)          state_d = StPivotIn;
        else if (piv_timeout) state_d = StFault;
      end
      StPivotIn: begin
        if (centre) begin
          pass_d  = (pass_q == 2'd2) ? pass_q : pass_q + 2'd1;
          state_d = (dir_q == DIR_UTURN && pass_q == 2'd0) ? StPivotOut : StFollow;
        end else if (piv_timeout) begin
          state_d = StFault;
        end
      end
      StDone, StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Timers restart on every entry into their state.
  always_comb begin
    adv_d = '0;
    if (state_q == StAdvance && state_d == StAdvance) begin
      adv_d = (adv_q == AdvMax) ? adv_q : adv_q + AW'(1);
    end
    piv_d = '0;
    if (in_pivot && state_d == state_q) begin
      piv_d = (piv_q == PivMax) ? piv_q : piv_q + PW'(1);
    end
  end

  // Output decode from the current state, registered below.
  always_comb begin
    ml_d     = MOT_STOP;
    mr_d     = MOT_STOP;
    corr_l_d = corr_l_q;
    corr_r_d = corr_r_q;
    ack_d    = (state_q == StAdvance) && (adv_q == '0);
    busy_d   = !(state_q == StIdle || state_q == StDone || state_q == StFault);
    done_d   = (state_q == StDone);
    fault_d  = (state_q == StFault);
    unique case (state_q)
      StFollow: begin
        case (line_sensor)
          3'b100, 3'b110: begin ml_d = MOT_STOP; mr_d = MOT_FWD;  end
          3'b001, 3'b011: begin ml_d = MOT_FWD;  mr_d = MOT_STOP; end
          3'b000:         begin ml_d = corr_l_q; mr_d = corr_r_q; end
          default:        begin ml_d = MOT_FWD;  mr_d = MOT_FWD;  end
        endcase
        if (line_sensor != 3'b000) begin
          corr_l_d = ml_d;
          corr_r_d = mr_d;
        end
      end
      StConfirm, StAdvance: begin
        ml_d = MOT_FWD;
        mr_d = MOT_FWD;
      end
      StPivotOut, StPivotIn: begin
        ml_d = (dir_q == DIR_LEFT) ? MOT_REV : MOT_FWD;
        mr_d = (dir_q == DIR_LEFT) ? MOT_FWD : MOT_REV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dir_q       <= DIR_STRAIGHT;
      pass_q      <= '0;
      adv_q       <= '0;
      piv_q       <= '0;
      corr_l_q    <= MOT_FWD;
      corr_r_q    <= MOT_FWD;
      motor_left  <= MOT_STOP;
      motor_right <= MOT_STOP;
      node_ack    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pass_q      <= pass_d;
      adv_q       <= adv_d;
      piv_q       <= piv_d;
      corr_l_q    <= corr_l_d;
      corr_r_q    <= corr_r_d;
      motor_left  <= ml_d;
      motor_right <= mr_d;
      node_ack    <= ack_d;
      busy        <= busy_d;
      done        <= done_d;
      fault       <= fault_d;
    end
  end

endmodule

// File: tb/tb_turn_maneuver_controller.sv
// Self-checking bench for turn_maneuver_controller with a node_ack scoreboard.
module tb_turn_maneuver_controller;
  import turn_ctrl_pkg::*;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Adv  = 8;
  localparam int unsigned Piv  = 100;
  localparam int unsigned Lost = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] line_sensor;
  logic [1:0] turn_direction;
  logic       route_done;
  logic [1:0] motor_left, motor_right;
  logic       node_ack, busy, done, fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] ack_q[$];
  logic       ack_prev = 1'b0;

  turn_maneuver_controller #(
    .DEBOUNCE_CYCLES (Deb),
    .ADVANCE_CYCLES  (Adv),
    .PIVOT_MAX_CYCLES(Piv),
    .LOST_MAX_CYCLES (Lost)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .line_sensor   (line_sensor),
    .turn_direction(turn_direction),
    .route_done    (route_done),
    .motor_left    (motor_left),
    .motor_right   (motor_right),
    .node_ack      (node_ack),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input int n);
    line_sensor = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each node_ack pops one expected {busy, motor_left, motor_right} entry.
  always @(negedge clk) begin
    if (reset) begin
      if (node_ack) begin
        check_eq("ack_single_pulse", 32'(ack_prev), 32'd0);
        check_eq("ack_expected", 32'(ack_q.size() != 0), 32'd1);
        if (ack_q.size() != 0) begin
          check_eq("ack_outputs", {27'd0, busy, motor_left, motor_right}, 32'(ack_q.pop_front()));
        end
      end
      ack_prev = node_ack;
    end
  end

  initial begin
    reset          = 1'b0;
    enable         = 1'b0;
    line_sensor    = 3'b010;
    turn_direction = DIR_STRAIGHT;
    route_done     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {25'd0, motor_left, motor_right, node_ack, busy, done, fault}, 0);
    reset = 1'b1;

    // Lane following by sensor pattern.
    enable = 1'b1;
    drive(3'b010, 10);
    check_eq("follow_010", {busy, motor_left, motor_right}, {1'b1, MOT_FWD, MOT_FWD});
    drive(3'b100, 2);
    check_eq("follow_100", {motor_left, motor_right}, {MOT_STOP, MOT_FWD});
    drive(3'b011, 2);
    check_eq("follow_011", {motor_left, motor_right}, {MOT_FWD, MOT_STOP});
    drive(3'b000, 3);
    check_eq("follow_hold", {motor_left, motor_right}, {MOT_FWD, MOT_STOP});
    drive(3'b101, 2);
    check_eq("follow_101", {motor_left, motor_right}, {MOT_FWD, MOT_FWD});
    drive(3'b110, 2);
    check_eq("follow_110", {motor_left, motor_right}, {MOT_STOP, MOT_FWD});

    // Left turn node.
    turn_direction = DIR_LEFT;
    ack_q.push_back({1'b1, MOT_FWD, MOT_FWD});
    drive(3'b111, Deb);
    drive(3'b010, 3);
    check_eq("advance_fwd", {busy, motor_left, motor_right}, {1'b1, MOT_FWD, MOT_FWD});
    drive(3'b010, 8);
    check_eq("pivot_left", {motor_left, motor_right}, {MOT_REV, MOT_FWD});
    drive(3'b000, 2);
    drive(3'b010, 1);
    drive(3'b100, 2);
    check_eq("left_back_follow", {motor_left, motor_right}, {MOT_STOP, MOT_FWD});
    check_eq("left_drained", ack_q.size(), 0);

    // Short 111 run must not confirm.
    drive(3'b111, Deb - 1);
    drive(3'b100, 3);
    check_eq("short_run_follow", {motor_left, motor_right}, {MOT_STOP, MOT_FWD});

    // Straight node: advance ignores sensors, then follow.
    turn_direction = DIR_STRAIGHT;
    ack_q.push_back({1'b1, MOT_FWD, MOT_FWD});
    drive(3'b111, Deb);
    drive(3'b100, 3);
    check_eq("straight_advance", {motor_left, motor_right}, {MOT_FWD, MOT_FWD});
    drive(3'b100, 7);
    check_eq("straight_follow", {motor_left, motor_right}, {MOT_STOP, MOT_FWD});
    check_eq("straight_drained", ack_q.size(), 0);

    // U-turn: two passes; direction change after confirm is ignored.
    turn_direction = DIR_UTURN;
    ack_q.push_back({1'b1, MOT_FWD, MOT_FWD});
    drive(3'b111, Deb);
    turn_direction = DIR_LEFT;
    drive(3'b010, 10);
    check_eq("uturn_pass1", {motor_left, motor_right}, {MOT_FWD, MOT_REV});
    drive(3'b000, 2);
    drive(3'b010, 2);
    check_eq("uturn_pass2", {busy, motor_left, motor_right}, {1'b1, MOT_FWD, MOT_REV});
    drive(3'b000, 2);
    drive(3'b010, 2);
    check_eq("uturn_follow", {motor_left, motor_right}, {MOT_FWD, MOT_FWD});
    check_eq("uturn_drained", ack_q.size(), 0);

    // Pivot timeout, exact boundary.
    turn_direction = DIR_RIGHT;
    ack_q.push_back({1'b1, MOT_FWD, MOT_FWD});
    drive(3'b111, Deb);
    drive(3'b010, Adv + Piv);
    check_eq("pivot_before_to", {fault, busy, motor_left, motor_right},
             {1'b0, 1'b1, MOT_FWD, MOT_REV});
    drive(3'b010, 1);
    check_eq("pivot_timeout", {fault, busy, motor_left, motor_right},
             {1'b1, 1'b0, MOT_STOP, MOT_STOP});
    drive(3'b010, 5);
    check_eq("fault_sticky", {fault, done}, 2'b10);
    enable = 1'b0;
    drive(3'b010, 2);
    check_eq("fault_to_idle", {fault, busy}, 2'b00);
    enable = 1'b1;
    drive(3'b100, 2);
    check_eq("idle_to_follow", {busy, motor_left, motor_right}, {1'b1, MOT_STOP, MOT_FWD});
    check_eq("timeout_drained", ack_q.size(), 0);

    // Route done at confirm.
    route_done = 1'b1;
    turn_direction = DIR_LEFT;
    drive(3'b111, Deb);
    drive(3'b010, 2);
    check_eq("route_done", {done, fault, busy, motor_left, motor_right},
             {1'b1, 1'b0, 1'b0, MOT_STOP, MOT_STOP});
    drive(3'b010, 5);
    check_eq("done_sticky", {done, busy}, 2'b10);
    enable = 1'b0;
    route_done = 1'b0;
    drive(3'b010, 2);
    check_eq("done_cleared", {done, busy}, 2'b00);
    enable = 1'b1;
    drive(3'b010, 3);

    // Enable drops on the confirm edge.
    drive(3'b111, Deb - 1);
    enable = 1'b0;
    drive(3'b111, 3);
    check_eq("abort_idle", {busy, motor_left, motor_right}, {1'b0, MOT_STOP, MOT_STOP});
    enable = 1'b1;
    drive(3'b100, 3);

    // Lost line.
    drive(3'b000, Lost - 1);
    check_eq("lost_before", {fault, busy, motor_left, motor_right},
             {1'b0, 1'b1, MOT_STOP, MOT_FWD});
    drive(3'b000, 2);
`ifdef TURN_LOST_LINE_TIMEOUT_EN
    check_eq("lost_fault", {fault, busy, motor_left, motor_right},
             {1'b1, 1'b0, MOT_STOP, MOT_STOP});
`else
    check_eq("lost_no_fault", {fault, busy, motor_left, motor_right},
             {1'b0, 1'b1, MOT_STOP, MOT_FWD});
    drive(3'b000, 1000);
    check_eq("lost_1000", {fault, busy, motor_left, motor_right},
             {1'b0, 1'b1, MOT_STOP, MOT_FWD});
`endif
    enable = 1'b0;
    drive(3'b010, 2);
    enable = 1'b1;
    drive(3'b010, 3);

    // Asynchronous reset mid-pivot.
    turn_direction = DIR_LEFT;
    ack_q.push_back({1'b1, MOT_FWD, MOT_FWD});
    drive(3'b111, Deb);
    drive(3'b010, 12);
    check_eq("pivot_pre_reset", {motor_left, motor_right}, {MOT_REV, MOT_FWD});
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_reset", {busy, motor_left, motor_right}, {1'b0, MOT_STOP, MOT_STOP});
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("final_drained", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
